// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink
//   Purpose     : OPB slave exposing C_NUM_REGS 32-bit control words to fabric logic,
//                 with byte-enable writes, readback and per-register update pulses.
//   Latency     : ack/read data registered one cycle after the accepting edge (E0);
//                 user_data_out/user_update change on E0 itself.
//   Backpressure: none; a transfer is accepted in IDLE only, then ACK and GAP are
//                 always traversed, so transfers are spaced at least 3 cycles apart.
// Optional feature: define OPB_REGBANK_SHADOW_EN to double-buffer the bank behind a
// CTRL commit register at offset 4*C_NUM_REGS.
// Ports:
//   OPB_Clk/OPB_Rst       clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW  OPB request (big-endian bit numbering, bit 0 = MSB)
//   OPB_select/seqAddr    transfer request / ignored
//   Sl_*                  OPB slave response (DBus, xferAck, errAck, retry=0, toutSup=0)
//   user_data_out         register i at bits [32i+31:32i]
//   user_update           one-cycle pulse per register when its output word changes
module opb_register_bank_ppc2simulink #(
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter logic [31:0] C_BASEADDR    = 32'h0100A300,
  parameter logic [31:0] C_HIGHADDR    = 32'h0100A3FF,
  parameter int          C_NUM_REGS    = 8,
  parameter logic [31:0] C_RESET_VALUE = 32'h00000000,
  parameter string       C_FAMILY      = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_update
);

  localparam logic [C_OPB_AWIDTH-1:0] BASE     = C_OPB_AWIDTH'(C_BASEADDR);
  localparam logic [C_OPB_AWIDTH-1:0] HIGH     = C_OPB_AWIDTH'(C_HIGHADDR);
  localparam logic [C_OPB_AWIDTH-1:0] CTRL_OFF = C_OPB_AWIDTH'(4 * C_NUM_REGS);

  typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;

  state_t state;

  // Bus fields re-numbered to little-endian: the plain assignment maps
  // OPB bit 0 (MSB) onto bit 31, so user bit b == OPB_DBus[31-b] and
  // be_u[3-k] == OPB_BE[k].
  logic [C_OPB_AWIDTH-1:0] addr;
  logic [31:0]             wdat;
  logic [3:0]              be_u;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic [31:0]             lane_mask;
  logic                    in_range;
  logic [C_NUM_REGS-1:0]   reg_sel;
  logic                    reg_hit;
  logic                    ctrl_hit;
  logic [31:0]             rd_val;
  logic [31:0]             rd_q;
  logic [31:0]             live [C_NUM_REGS];
`ifdef OPB_REGBANK_SHADOW_EN
  logic [31:0]             shadow [C_NUM_REGS];
  logic [C_NUM_REGS-1:0]   dirty;
`endif

  assign addr      = OPB_ABus;
  assign wdat      = OPB_DBus;
  assign be_u      = OPB_BE;
  assign offset    = addr - BASE;
  assign in_range  = (addr >= BASE) && (addr <= HIGH);
  assign lane_mask = {{8{be_u[3]}}, {8{be_u[2]}}, {8{be_u[1]}}, {8{be_u[0]}}};
  assign ctrl_hit  = in_range && (offset == CTRL_OFF);
  assign reg_hit   = |reg_sel;

  // One-hot register select; unaligned offsets never match, so they fall
  // through to the error response.
  always_comb begin
    reg_sel = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      reg_sel[i] = in_range && (offset == C_OPB_AWIDTH'(4 * i));
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
`ifdef OPB_REGBANK_SHADOW_EN
      if (reg_sel[i]) rd_val = rd_val | shadow[i];
`else
      if (reg_sel[i]) rd_val = rd_val | live[i];
`endif
    end
`ifdef OPB_REGBANK_SHADOW_EN
    if (ctrl_hit) rd_val = 32'(dirty);
`endif
    rd_val = rd_val & lane_mask;
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state       <= IDLE;
      Sl_xferAck  <= 1'b0;
      Sl_errAck   <= 1'b0;
      rd_q        <= '0;
      user_update <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        live[i] <= C_RESET_VALUE;
`ifdef OPB_REGBANK_SHADOW_EN
        shadow[i] <= C_RESET_VALUE;
`endif
      end
`ifdef OPB_REGBANK_SHADOW_EN
      dirty <= '0;
`endif
    end else begin
      user_update <= '0;
      case (state)
        IDLE: begin
          if (OPB_select && in_range) begin
            state      <= ACK;
            Sl_xferAck <= 1'b1;
            Sl_errAck  <= !(reg_hit || ctrl_hit);
            rd_q       <= OPB_RNW ? rd_val : 32'h0;
            if (!OPB_RNW && (be_u != 4'b0000)) begin
              for (int i = 0; i < C_NUM_REGS; i++) begin
                if (reg_sel[i]) begin
`ifdef OPB_REGBANK_SHADOW_EN
                  shadow[i] <= merge_bytes(shadow[i], wdat, be_u);
                  dirty[i]  <= 1'b1;
`else
                  live[i]        <= merge_bytes(live[i], wdat, be_u);
                  user_update[i] <= 1'b1;
`endif
                end
              end
`ifdef OPB_REGBANK_SHADOW_EN
              // Commit needs the lane carrying user bit 0 enabled and that bit set.
              if (ctrl_hit && be_u[0] && wdat[0]) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                  if (dirty[i]) live[i] <= shadow[i];
                end
                user_update <= dirty;
                dirty       <= '0;
              end
`endif
            end
          end
        end
        ACK: begin
          state      <= GAP;
          Sl_xferAck <= 1'b0;
          Sl_errAck  <= 1'b0;
          rd_q       <= '0;
        end
        // Select is ignored here so a master that is slow to drop it
        // does not start a second transfer.
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < C_NUM_REGS; g++) begin : g_out
      assign user_data_out[32*g +: 32] = live[g];
    end
  endgenerate

  assign Sl_DBus    = rd_q;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, OPB_seqAddr, (C_FAMILY != "")};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
module tb_opb_register_bank_ppc2simulink;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h0100A300;
  localparam logic [31:0] HIGH = 32'h0100A3FF;
  localparam logic [31:0] RV   = 32'h00000000;

  logic           clk = 1'b0;
  logic           rst;
  logic [0:31]    abus;
  logic [0:3]     be;
  logic [0:31]    dbus;
  logic           rnw, sel, seq;
  logic [0:31]    sl_dbus;
  logic           ack, err, retry, tout;
  logic [32*N-1:0] udo;
  logic [N-1:0]   upd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(retry),
    .Sl_toutSup(tout), .user_data_out(udo), .user_update(upd)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_live [N];
  logic [31:0] m_shadow [N];
  logic [N-1:0] m_dirty;
  int          m_gap;
  logic        m_ack, m_err;
  logic [31:0] m_rd;
  logic [N-1:0] m_upd;
  bit          m_valid = 0;
  logic [31:0] mv_a, mv_off, mv_wd, mv_mask;
  int          mv_idx;

  function automatic logic [32*N-1:0] pack_live();
    logic [32*N-1:0] p;
    for (int i = 0; i < N; i++) p[32*i +: 32] = m_live[i];
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_live[i] = RV; m_shadow[i] = RV; end
      m_dirty = '0; m_gap = 0; m_ack = 0; m_err = 0; m_rd = '0; m_upd = '0;
      m_valid = 1;
    end else begin
      m_ack = 0; m_err = 0; m_rd = '0; m_upd = '0;
      if (m_gap > 0) m_gap--;
      else if (sel && abus >= BASE && abus <= HIGH) begin
        mv_a = abus; mv_wd = dbus;
        mv_off = mv_a - BASE;
        m_gap = 2; m_ack = 1;
        mv_mask = '0;
        for (int k = 0; k < 4; k++) if (be[k]) mv_mask[31-8*k -: 8] = 8'hFF;
        if (mv_off % 4 == 0 && mv_off / 4 < N) begin
          mv_idx = int'(mv_off / 4);
          if (rnw) begin
`ifdef OPB_REGBANK_SHADOW_EN
            m_rd = m_shadow[mv_idx] & mv_mask;
`else
            m_rd = m_live[mv_idx] & mv_mask;
`endif
          end else if (mv_mask != 0) begin
`ifdef OPB_REGBANK_SHADOW_EN
            m_shadow[mv_idx] = (m_shadow[mv_idx] & ~mv_mask) | (mv_wd & mv_mask);
            m_dirty[mv_idx] = 1'b1;
`else
            m_live[mv_idx] = (m_live[mv_idx] & ~mv_mask) | (mv_wd & mv_mask);
            m_upd[mv_idx] = 1'b1;
`endif
          end
        end else if (mv_off == 4 * N) begin
`ifdef OPB_REGBANK_SHADOW_EN
          if (rnw) m_rd = 32'(m_dirty) & mv_mask;
          else if (mv_wd[0] && be[3]) begin
            for (int i = 0; i < N; i++) if (m_dirty[i]) m_live[i] = m_shadow[i];
            m_upd = m_dirty;
            m_dirty = '0;
          end
`endif
        end else begin
          m_err = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] cmp_rd;
  always @(negedge clk) begin
    if (m_valid) begin
      cmp_rd = sl_dbus;
      chk("xfer_ack", 256'(ack), 256'(m_ack));
      chk("err_ack", 256'(err), 256'(m_err));
      chk("sl_dbus", 256'(cmp_rd), 256'(m_rd));
      chk("user_update", 256'(upd), 256'(m_upd));
      chk("user_data_out", 256'(udo), 256'(pack_live()));
      chk("retry_tout", 256'({retry, tout}), 256'(0));
    end
  end

  // ---------------- bus driver ----------------
  task automatic xfer(input logic [31:0] a, input bit r, input logic [0:3] b,
                      input logic [31:0] d, input bit hold,
                      output logic [31:0] rd, output logic ak, output logic er,
                      output logic [N-1:0] up, output logic [32*N-1:0] ud);
    @(negedge clk);
    abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
    @(posedge clk); #1;
    ak = ack; er = err; rd = sl_dbus; up = upd; ud = udo;
    @(negedge clk); sel = hold;
    @(negedge clk); sel = hold;
    @(negedge clk); sel = 1'b0;
  endtask

  logic [31:0]     rd;
  logic            ak, er;
  logic [N-1:0]    up;
  logic [32*N-1:0] ud;
  logic [31:0]     ra, rdat;
  int              kind, ri;

  initial begin
    rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ack", 256'(ack), 256'(0));
    chk("reset_dbus", 256'(sl_dbus), 256'(0));
    chk("reset_udo", 256'(udo), 256'(0));
    rst = 1'b0;

    // all registers read back as reset value
    for (int i = 0; i < N; i++) begin
      xfer(BASE + 32'(4*i), 1'b1, 4'b1111, 32'h0, 1'b0, rd, ak, er, up, ud);
      chk("init_read", 256'(rd), 256'(32'h0));
      chk("init_ack", 256'(ak), 256'(1));
      chk("init_upd", 256'(up), 256'(0));
    end

    // full write to register 3
    xfer(BASE + 32'd12, 1'b0, 4'b1111, 32'hA5A51234, 1'b0, rd, ak, er, up, ud);
    chk("wr3_ack", 256'(ak), 256'(1));
`ifdef OPB_REGBANK_SHADOW_EN
    chk("wr3_upd", 256'(up), 256'(8'b0000_0000));
    chk("wr3_udo", 256'(ud[127:96]), 256'(32'h0));
`else
    chk("wr3_upd", 256'(up), 256'(8'b0000_1000));
    chk("wr3_udo", 256'(ud[127:96]), 256'(32'hA5A51234));
    chk("model_reg3", 256'(m_live[3]), 256'(32'hA5A51234));
`endif
    xfer(BASE + 32'd12, 1'b1, 4'b1111, 32'h0, 1'b0, rd, ak, er, up, ud);
    chk("rd3", 256'(rd), 256'(32'hA5A51234));

    // single byte lane, then no lanes
    xfer(BASE, 1'b0, 4'b0100, 32'hFFFFFFFF, 1'b0, rd, ak, er, up, ud);
    xfer(BASE, 1'b1, 4'b1111, 32'h0, 1'b0, rd, ak, er, up, ud);
    chk("rd0_lane1", 256'(rd), 256'(32'h00FF0000));
    xfer(BASE, 1'b0, 4'b0000, 32'hFFFFFFFF, 1'b0, rd, ak, er, up, ud);
    chk("be0_ack", 256'(ak), 256'(1));
    chk("be0_upd", 256'(up), 256'(0));
    xfer(BASE, 1'b1, 4'b1111, 32'h0, 1'b0, rd, ak, er, up, ud);
    chk("rd0_after_be0", 256'(rd), 256'(32'h00FF0000));
    xfer(BASE, 1'b1, 4'b0011, 32'h0, 1'b0, rd, ak, er, up, ud);
    chk("rd0_masked", 256'(rd), 256'(32'h0));

`ifdef OPB_REGBANK_SHADOW_EN
    // flush what is pending (reg0, reg3), then the two-register commit
    xfer(BASE + 32'(4*N), 1'b0, 4'b0001, 32'h1, 1'b0, rd, ak, er, up, ud);
    chk("flush_upd", 256'(up), 256'(8'b0000_1001));
    xfer(BASE + 32'd4,  1'b0, 4'b1111, 32'h11111111, 1'b0, rd, ak, er, up, ud);
    xfer(BASE + 32'd20, 1'b0, 4'b1111, 32'h55555555, 1'b0, rd, ak, er, up, ud);
    xfer(BASE + 32'(4*N), 1'b1, 4'b1111, 32'h0, 1'b0, rd, ak, er, up, ud);
    chk("ctrl_dirty", 256'(rd), 256'(32'h00000022));
    chk("pre_commit_udo", 256'(ud[63:32]), 256'(32'h0));
    xfer(BASE + 32'(4*N), 1'b0, 4'b0001, 32'h1, 1'b0, rd, ak, er, up, ud);
    chk("commit_upd", 256'(up), 256'(8'b0010_0010));
    chk("commit_r1", 256'(ud[63:32]), 256'(32'h11111111));
    chk("commit_r5", 256'(ud[191:160]), 256'(32'h55555555));
    xfer(BASE + 32'(4*N), 1'b1, 4'b1111, 32'h0, 1'b0, rd, ak, er, up, ud);
    chk("ctrl_cleared", 256'(rd), 256'(32'h0));
    xfer(BASE + 32'(4*N), 1'b0, 4'b0001, 32'h1, 1'b0, rd, ak, er, up, ud);
    chk("empty_commit_upd", 256'(up), 256'(0));
`else
    xfer(BASE + 32'(4*N), 1'b0, 4'b1111, 32'h1, 1'b0, rd, ak, er, up, ud);
    chk("ctrl_wr_ack", 256'(ak), 256'(1));
    chk("ctrl_wr_upd", 256'(up), 256'(0));
    xfer(BASE + 32'(4*N), 1'b1, 4'b1111, 32'h0, 1'b0, rd, ak, er, up, ud);
    chk("ctrl_rd_zero", 256'(rd), 256'(32'h0));
`endif

    // undecoded offset inside the window
    xfer(BASE + 32'h44, 1'b0, 4'b1111, 32'hDEADBEEF, 1'b0, rd, ak, er, up, ud);
    chk("err_wr_ack", 256'({ak, er}), 256'(2'b11));
    chk("err_wr_upd", 256'(up), 256'(0));
    xfer(BASE + 32'h44, 1'b1, 4'b1111, 32'h0, 1'b0, rd, ak, er, up, ud);
    chk("err_rd", 256'({ak, er, rd}), 256'({2'b11, 32'h0}));
    xfer(BASE + 32'h2, 1'b1, 4'b1111, 32'h0, 1'b0, rd, ak, er, up, ud);
    chk("unaligned_err", 256'({ak, er}), 256'(2'b11));
    // outside the window
    xfer(HIGH + 32'd1, 1'b1, 4'b1111, 32'h0, 1'b0, rd, ak, er, up, ud);
    chk("oor_hi_noack", 256'(ak), 256'(0));
    xfer(BASE - 32'd4, 1'b0, 4'b1111, 32'h12345678, 1'b0, rd, ak, er, up, ud);
    chk("oor_lo_noack", 256'(ak), 256'(0));

    // randomized traffic, all checking via the per-cycle compare
    for (int t = 0; t < 400; t++) begin
      kind = $urandom_range(0, 9);
      ri   = $urandom_range(0, N-1);
      rdat = $urandom;
      if (kind <= 5)      ra = BASE + 32'(4*ri);
      else if (kind == 6) begin ra = BASE + 32'(4*N); rdat[0] = ($urandom_range(0, 1) == 1); end
      else if (kind == 7) ra = BASE + 32'($urandom_range(4*N+1, 255));
      else if (kind == 8) ra = BASE + 32'(4*ri) + 32'($urandom_range(1, 3));
      else                ra = ($urandom_range(0, 1) == 1) ? HIGH + 32'($urandom_range(1, 64))
                                                            : BASE - 32'($urandom_range(1, 64));
      xfer(ra, ($urandom_range(0, 1) == 1), 4'($urandom), rdat,
           ($urandom_range(0, 3) == 0), rd, ak, er, up, ud);
    end

    // reset during the ACK cycle
    @(negedge clk);
    abus = BASE + 32'd8; rnw = 1'b0; be = 4'b1111; dbus = 32'hCAFEF00D; sel = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ack_before", 256'(ack), 256'(1));
    @(negedge clk); sel = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ack", 256'(ack), 256'(0));
    chk("rst_mid_udo", 256'(udo), 256'({N{RV}}));
    chk("rst_mid_upd", 256'(upd), 256'(0));
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_late_ack", 256'(ack), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
# opb_register_bank_ppc2simulink

Multi-register OPB slave that gives PowerPC software a bank of C_NUM_REGS 32-bit control words driven into the fabric user logic (equaliser coefficients, gains, mode bits) over the shared OPB bus. It adds byte-enable writes, readback and per-register update strobes. Optionally it double-buffers the bank so that all pending writes reach the fabric together on a single commit. It sits on the OPB alongside the existing single-word software registers, clocked entirely from OPB_Clk.

## Interface
- C_BASEADDR, 32'h0100A300: first byte address of the slave.
- C_HIGHADDR, 32'h0100A3FF: last byte address decoded by the slave.
- C_NUM_REGS, 8: number of user registers, 1..16.
- C_RESET_VALUE, 32'h00000000: reset value of every user and shadow register.
- C_OPB_AWIDTH, 32: OPB address width.
- C_OPB_DWIDTH, 32: OPB data width, fixed at 32.
- C_FAMILY, "virtex5": target family.

Ports:
- OPB_Clk  in  1  sole clock; all logic is on the rising edge.
- OPB_Rst  in  1  reset, synchronous, active-high.
- OPB_ABus  in  [0:31]  byte address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers OPB_DBus[0:7].
- OPB_DBus  in  [0:31]  write data; bit 0 is the MSB.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero except in the ack cycle of a read.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck  out  1  error; asserted only with Sl_xferAck.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- user_data_out  out  [32*C_NUM_REGS-1:0]  register i at bits [32i+31:32i].
- user_update  out  [C_NUM_REGS-1:0]  one-cycle pulse when register i changes on user_data_out.

## Operation
- Address map, offset = OPB_ABus - C_BASEADDR:
  - 4i for i < C_NUM_REGS addresses register i.
  - 4*C_NUM_REGS addresses CTRL.
  - Other offsets up to C_HIGHADDR are acked with Sl_errAck=1; the write is dropped and the read returns 0.
  - Addresses outside C_BASEADDR..C_HIGHADDR are ignored and not acked.
- Bit mapping: user bit b maps to OPB_DBus[31-b]. Byte enable BE[k] writes user bits [31-8k:24-8k].
- FSM, with states IDLE, ACK and GAP:
  - IDLE -> ACK when OPB_select is high and the address is decoded. The write is applied on this edge.
  - ACK -> GAP unconditionally.
  - GAP -> IDLE unconditionally. GAP ignores OPB_select, which guards against a master that holds select for one cycle after the ack.
- Writes: only the enabled bytes change. A write with BE=0000 is acked, changes nothing and sets no dirty bit.
- Reads return register i's shadow (or its live value when there is no shadow) on the lanes where the BE is set; other lanes read 0.
- CTRL register:
  - A read returns the dirty mask in user bits [C_NUM_REGS-1:0], zero-extended.
  - A write with user bit 0 = 1 and BE[3] = 1 performs a commit. Other CTRL writes are acked and have no effect.
- Dirty mask: bit i is set by a byte-enabled write to register i and cleared on commit.

## Timing
- Reset: all registers equal C_RESET_VALUE. Dirty mask = 0, FSM = IDLE. Sl_xferAck, Sl_errAck and user_update = 0, and Sl_DBus = 0.
- Edge E0 is the edge at which the FSM leaves IDLE. Sl_xferAck, Sl_errAck and Sl_DBus are registered and valid in the cycle after E0 (latency 1). The next transfer can be accepted no earlier than 3 cycles after the previous one.
- user_data_out and user_update both change on the edge at which the corresponding register or commit is applied. The pulse lasts exactly one cycle.
- If reset is asserted mid-transfer (in ACK or GAP), the block returns to the reset state on that edge and no further ack is issued. Pending dirty state is lost.

## Configuration
- OPB_REGBANK_SHADOW_EN defined:
  - Writes go to the shadow registers only.
  - A commit copies every dirty shadow into user_data_out on E0, pulses user_update for exactly the dirty bits and clears the dirty mask.
  - A commit with an empty dirty mask produces no pulse and no change.
- OPB_REGBANK_SHADOW_EN undefined:
  - No shadows. Writes update user_data_out directly on E0 and pulse user_update[i] whenever any byte is enabled.
  - The CTRL register reads 0, and CTRL writes are acked with no effect.

## Test plan
- Reset, then read registers 0..7 -> every read returns 32'h00000000 with one ack, and user_update stays 0.
- No shadow: write 32'hA5A5_1234 to register 3 with BE=1111 -> user_data_out[127:96]=A5A51234 on E0, user_update=8'b0000_1000 for one cycle, and Sl_xferAck on the next cycle.
- Write 32'hFFFFFFFF to register 0 with BE=0100 -> register 0 reads 32'h00FF0000. Then write with BE=0000 -> no change and no pulse.
- Shadow: write registers 1 and 5, read CTRL -> 32'h00000022 with user_data_out unchanged. Write 1 to CTRL -> both words appear on the same edge, user_update=8'b0010_0010, and CTRL then reads 0.
- Access offset 0x40 (C_NUM_REGS=8) -> Sl_xferAck and Sl_errAck both high for one cycle, with no state change.
- Assert OPB_Rst during the ACK cycle -> Sl_xferAck is 0 on the next cycle and all registers equal C_RESET_VALUE.
